// File: rtl/resp_pkg.sv
// resp_pkg -- shared constants for the response framer.
//   Response code bytes sent as the first byte of every frame, the FSM state
//   encoding, and the number of bytes per frame.
//   Optional feature macro: RESPONSE_CHECKSUM_EN (adds a third checksum byte).
package resp_pkg;

    // Response code bytes
    localparam logic [7:0] CODE_ERROR         = 8'h1F;
    localparam logic [7:0] CODE_SENSOR_OK     = 8'h07;
    localparam logic [7:0] CODE_HUMIDITY      = 8'h09;
    localparam logic [7:0] CODE_TEMPERATURE   = 8'h08;
    localparam logic [7:0] CODE_TEMP_CONT_OFF = 8'h0A;
    localparam logic [7:0] CODE_HUM_CONT_OFF  = 8'h0B;
    localparam logic [7:0] CODE_INVALID       = 8'hFF;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_CODE = 3'd1;
    localparam logic [2:0] ST_WAIT_CODE = 3'd2;
    localparam logic [2:0] ST_SEND_DATA = 3'd3;
    localparam logic [2:0] ST_WAIT_DATA = 3'd4;
`ifdef RESPONSE_CHECKSUM_EN
    localparam logic [2:0] ST_SEND_CSUM = 3'd5;
    localparam logic [2:0] ST_WAIT_CSUM = 3'd6;
`endif

    // Bytes per transmitted frame
`ifdef RESPONSE_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 3;
`else
    localparam int unsigned FRAME_LEN = 2;
`endif

endpackage

// File: rtl/resp_encoder.sv
// resp_encoder -- combinational mapping of the one-hot response selector to
// a code byte and payload byte.
//   i_comandos : one-hot selector (bit0 error ... bit5 hum-continuous off)
//   i_data     : payload byte from the sensor interface
//   o_valid    : selector is non-zero (a frame should be produced)
//   o_code     : response code byte
//   o_payload  : payload byte (forced to 0x00 for invalid selectors)
module resp_encoder
    import resp_pkg::*;
(
    input  logic [5:0] i_comandos,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output logic [7:0] o_code,
    output logic [7:0] o_payload
);

    always_comb begin
        o_valid   = |i_comandos;
        o_code    = CODE_INVALID;
        o_payload = '0;
        // Error wins over any other bit set alongside it.
        if (i_comandos[0]) begin
            o_code    = CODE_ERROR;
            o_payload = i_data;
        end else begin
            case (i_comandos)
                6'b000010: begin o_code = CODE_SENSOR_OK;     o_payload = i_data; end
                6'b000100: begin o_code = CODE_HUMIDITY;      o_payload = i_data; end
                6'b001000: begin o_code = CODE_TEMPERATURE;   o_payload = i_data; end
                6'b010000: begin o_code = CODE_TEMP_CONT_OFF; o_payload = i_data; end
                6'b100000: begin o_code = CODE_HUM_CONT_OFF;  o_payload = i_data; end
                default: begin
                    o_code    = CODE_INVALID;
                    o_payload = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/response_framer.sv
// response_framer -- turns sensor results into UART byte frames
// (code byte, payload byte, optional checksum byte).
//   Optional feature macro: RESPONSE_CHECKSUM_EN -- appends code^payload as a
//   third byte.
//   i_Clock, i_Rst_n     : clock, asynchronous active-low reset
//   i_done/i_comandos/i_data : result pulse, one-hot selector, payload
//   o_tx_data/o_tx_start : byte and one-cycle start pulse to the UART
//   i_tx_done            : one-cycle byte-sent pulse from the UART
//   o_busy               : frame in progress or a result is pending
//   o_overflow           : sticky, a result was dropped (slot full)
//   o_tx_timeout         : sticky, a frame was aborted on UART timeout
//   TX_TIMEOUT           : cycles from o_tx_start to abort (use >= 2)
module response_framer
    import resp_pkg::*;
#(
    parameter int unsigned TX_TIMEOUT = 100000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_done,
    input  logic [5:0] i_comandos,
    input  logic [7:0] i_data,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_done,
    output logic       o_busy,
    output logic       o_overflow,
    output logic       o_tx_timeout
);

    localparam int unsigned CW = $clog2(TX_TIMEOUT + 1);

    logic [2:0]    state_q,     state_d;
    logic          pend_full_q, pend_full_d;
    logic [7:0]    pend_code_q, pend_code_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic [7:0]    code_q,      code_d;
    logic [7:0]    data_q,      data_d;
    logic [7:0]    tx_data_q,   tx_data_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          overflow_q,  overflow_d;
    logic          timeout_q,   timeout_d;

    logic          enc_valid;
    logic [7:0]    enc_code;
    logic [7:0]    enc_payload;
    logic          timeout_hit;

    resp_encoder u_encoder (
        .i_comandos (i_comandos),
        .i_data     (i_data),
        .o_valid    (enc_valid),
        .o_code     (enc_code),
        .o_payload  (enc_payload)
    );

    // cnt_q equals the number of cycles since the start pulse while waiting,
    // so the abort lands exactly TX_TIMEOUT cycles after o_tx_start.
    assign timeout_hit = (cnt_q >= CW'(TX_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        pend_full_d = pend_full_q;
        pend_code_d = pend_code_q;
        pend_data_d = pend_data_q;
        code_d      = code_q;
        data_d      = data_q;
        tx_data_d   = tx_data_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_full_q) begin
                    state_d     = ST_SEND_CODE;
                    code_d      = pend_code_q;
                    data_d      = pend_data_q;
                    tx_data_d   = pend_code_q;
                    pend_full_d = 1'b0;
                end
            end
            ST_SEND_CODE: begin
                state_d = ST_WAIT_CODE;
                cnt_d   = CW'(1);
            end
            ST_WAIT_CODE: begin
                if (i_tx_done) begin
                    state_d   = ST_SEND_DATA;
                    tx_data_d = data_q;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SEND_DATA: begin
                state_d = ST_WAIT_DATA;
                cnt_d   = CW'(1);
            end
            ST_WAIT_DATA: begin
                if (i_tx_done) begin
`ifdef RESPONSE_CHECKSUM_EN
                    state_d   = ST_SEND_CSUM;
                    tx_data_d = code_q ^ data_q;
`else
                    state_d   = ST_IDLE;
`endif
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef RESPONSE_CHECKSUM_EN
            ST_SEND_CSUM: begin
                state_d = ST_WAIT_CSUM;
                cnt_d   = CW'(1);
            end
            ST_WAIT_CSUM: begin
                if (i_tx_done) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The slot is judged by its registered value: a result arriving in
        // the same cycle the slot is being emptied is still dropped.
        if (i_done && enc_valid) begin
            if (pend_full_q) begin
                overflow_d = 1'b1;
            end else begin
                pend_full_d = 1'b1;
                pend_code_d = enc_code;
                pend_data_d = enc_payload;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            pend_full_q <= 1'b0;
            pend_code_q <= '0;
            pend_data_q <= '0;
            code_q      <= '0;
            data_q      <= '0;
            tx_data_q   <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            pend_code_q <= pend_code_d;
            pend_data_q <= pend_data_d;
            code_q      <= code_d;
            data_q      <= data_d;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef RESPONSE_CHECKSUM_EN
    assign o_tx_start = (state_q == ST_SEND_CODE) || (state_q == ST_SEND_DATA) ||
                        (state_q == ST_SEND_CSUM);
`else
    assign o_tx_start = (state_q == ST_SEND_CODE) || (state_q == ST_SEND_DATA);
`endif
    assign o_tx_data    = tx_data_q;
    assign o_busy       = (state_q != ST_IDLE) || pend_full_q;
    assign o_overflow   = overflow_q;
    assign o_tx_timeout = timeout_q;

endmodule

// File: tb/tb_response_framer.sv
// tb_response_framer -- randomized and directed checks of response_framer
// against a byte-queue reference model.
module tb_response_framer;
    import resp_pkg::*;

    localparam int unsigned TMO = 20;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_done = 1'b0;
    logic [5:0] cmd = '0;
    logic [7:0] din = '0;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_overflow;
    logic       o_tx_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_cyc = 0;
    int n_starts = 0;
    bq_t sent;

    // UART responder controls
    bit rsp_en = 1'b1;
    bit rsp_rand = 1'b0;
    bit rsp_noise = 1'b0;
    int rsp_cd = -1;

    // Reference model state
    bq_t        m_pend;
    bq_t        m_act;
    bit         m_pend_v = 1'b0;
    int         m_phase = 0;   // 0 no frame, 1 start cycle, 2 awaiting done
    logic [7:0] m_data = '0;
    bit         m_ovf = 1'b0;
    bit         m_tmo = 1'b0;
    int         m_cyc = 0;
    int         m_start = 0;

    response_framer #(.TX_TIMEOUT(TMO)) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_done       (i_done),
        .i_comandos   (cmd),
        .i_data       (din),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_tx_timeout (o_tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(string nm, int limit);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no response within %0d cycles at t=%0t", nm, limit, $time);
    endtask

    // Frame the specification's rules produce for one accepted result.
    function automatic bq_t frame_of(logic [5:0] c, logic [7:0] d);
        logic [7:0] tbl [6];
        logic [7:0] code;
        logic [7:0] pay;
        bq_t f;
        tbl = '{8'h1F, 8'h07, 8'h09, 8'h08, 8'h0A, 8'h0B};
        code = 8'hFF;
        pay  = 8'h00;
        if (c[0]) begin
            code = tbl[0];
            pay  = d;
        end else if ($countones(c) == 1) begin
            for (int i = 1; i < 6; i++) if (c[i]) code = tbl[i];
            pay = d;
        end
        f.push_back(code);
        f.push_back(pay);
`ifdef RESPONSE_CHECKSUM_EN
        f.push_back(code ^ pay);
`endif
        return f;
    endfunction

    task automatic model_step();
        bit had_pend;
        if (!rst_n) begin
            m_pend.delete();
            m_act.delete();
            m_pend_v = 1'b0;
            m_phase  = 0;
            m_data   = '0;
            m_ovf    = 1'b0;
            m_tmo    = 1'b0;
            return;
        end
        had_pend = m_pend_v;
        if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (i_tx_done) begin
                void'(m_act.pop_front());
                if (m_act.size() > 0) begin
                    m_phase = 1;
                    m_data  = m_act[0];
                    m_start = m_cyc + 1;
                end else begin
                    m_phase = 0;
                end
            end else if (m_cyc + 1 - m_start >= int'(TMO)) begin
                m_act.delete();
                m_phase = 0;
                m_tmo   = 1'b1;
            end
        end else if (had_pend) begin
            m_act    = m_pend;
            m_pend_v = 1'b0;
            m_phase  = 1;
            m_data   = m_act[0];
            m_start  = m_cyc + 1;
        end
        if (i_done && cmd != 6'b0) begin
            if (had_pend) m_ovf = 1'b1;
            else begin
                m_pend   = frame_of(cmd, din);
                m_pend_v = 1'b1;
            end
        end
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        tb_cyc++;
    end

    // Per-cycle comparison against the model, plus byte capture.
    initial forever begin
        @(negedge clk);
        if (o_tx_start === 1'b1) begin
            sent.push_back(o_tx_data);
            n_starts++;
        end
        chk("busy",       {31'b0, o_busy},       {31'b0, (m_pend_v || m_phase != 0)});
        chk("tx_start",   {31'b0, o_tx_start},   {31'b0, (m_phase == 1)});
        chk("tx_data",    {24'b0, o_tx_data},    {24'b0, m_data});
        chk("overflow",   {31'b0, o_overflow},   {31'b0, m_ovf});
        chk("tx_timeout", {31'b0, o_tx_timeout}, {31'b0, m_tmo});
    end

    // UART transmitter stand-in: done pulse N cycles after each start.
    initial forever begin
        @(negedge clk);
        if (o_tx_start === 1'b1 && rsp_en)
            rsp_cd = rsp_rand ? int'($urandom_range(1, 25)) : 10;
        @(posedge clk);
        #2;
        i_tx_done = 1'b0;
        if (rsp_cd > 0) begin
            rsp_cd--;
            if (rsp_cd == 0) begin
                i_tx_done = 1'b1;
                rsp_cd = -1;
            end
        end else if (rsp_noise && $urandom_range(0, 19) == 0) begin
            i_tx_done = 1'b1;
        end
    end

    task automatic pulse(logic [5:0] c, logic [7:0] d);
        @(posedge clk);
        #2;
        cmd = c;
        din = d;
        i_done = 1'b1;
        @(posedge clk);
        #2;
        i_done = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rsp_cd = -1;
        #1;
        chk("rst_tx_start", {31'b0, o_tx_start}, 32'd0);
        chk("rst_tx_data",  {24'b0, o_tx_data},  32'd0);
        chk("rst_busy",     {31'b0, o_busy},     32'd0);
        chk("rst_overflow", {31'b0, o_overflow}, 32'd0);
        chk("rst_timeout",  {31'b0, o_tx_timeout}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_start(string nm, int limit);
        int k = 0;
        while (o_tx_start !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) bound_fail(nm, limit);
    endtask

    task automatic wait_idle(string nm, int limit);
        int k = 0;
        while (o_busy !== 1'b0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) bound_fail(nm, limit);
    endtask

    task automatic check_bytes(string nm, bq_t exp);
        chk({nm, "_len"}, sent.size(), exp.size());
        if (sent.size() == exp.size())
            for (int i = 0; i < exp.size(); i++)
                chk($sformatf("%s_b%0d", nm, i), {24'b0, sent[i]}, {24'b0, exp[i]});
    endtask

    initial begin
        bq_t f;
        bq_t e;
        int s;
        int n0;

        // Pin the model against hand-computed frames.
        f = frame_of(6'b001000, 8'h19);
        chk("pin_temp_code", {24'b0, f[0]}, 32'h08);
        chk("pin_temp_data", {24'b0, f[1]}, 32'h19);
        f = frame_of(6'b000101, 8'h33);
        chk("pin_err_code", {24'b0, f[0]}, 32'h1F);
        f = frame_of(6'b001100, 8'h44);
        chk("pin_multi_code", {24'b0, f[0]}, 32'hFF);
        chk("pin_multi_data", {24'b0, f[1]}, 32'h00);

        reset_dut();

        // Temperature response, done 10 cycles after each start.
        sent.delete();
        pulse(6'b001000, 8'h19);
        wait_idle("temp_frame", 200);
        e = '{8'h08, 8'h19};
`ifdef RESPONSE_CHECKSUM_EN
        e.push_back(8'h11);
`endif
        check_bytes("temp", e);

        // Error priority and invalid multi-bit selector.
        sent.delete();
        pulse(6'b000101, 8'h33);
        wait_idle("err_frame", 200);
        e = '{8'h1F, 8'h33};
`ifdef RESPONSE_CHECKSUM_EN
        e.push_back(8'h2C);
`endif
        check_bytes("err", e);
        sent.delete();
        pulse(6'b001100, 8'h44);
        wait_idle("multi_frame", 200);
        e = '{8'hFF, 8'h00};
`ifdef RESPONSE_CHECKSUM_EN
        e.push_back(8'hFF);
`endif
        check_bytes("multi", e);

        // Zero selector is ignored.
        sent.delete();
        pulse(6'b000000, 8'h77);
        repeat (15) @(negedge clk);
        chk("zero_sel_bytes", sent.size(), 32'd0);
        chk("zero_sel_busy", {31'b0, o_busy}, 32'd0);

        // Three results 5 cycles apart: third is dropped.
        sent.delete();
        pulse(6'b000010, 8'hA1);
        repeat (3) @(posedge clk);
        pulse(6'b000100, 8'hB2);
        repeat (3) @(posedge clk);
        pulse(6'b010000, 8'hC3);
        wait_idle("overflow_frames", 400);
        e = '{8'h07, 8'hA1};
`ifdef RESPONSE_CHECKSUM_EN
        e.push_back(8'hA6);
`endif
        e.push_back(8'h09);
        e.push_back(8'hB2);
`ifdef RESPONSE_CHECKSUM_EN
        e.push_back(8'hBB);
`endif
        check_bytes("ovf", e);
        chk("ovf_flag", {31'b0, o_overflow}, 32'd1);

        // Timeout: tx_done withheld.
        rsp_en = 1'b0;
        sent.delete();
        pulse(6'b000010, 8'h5A);
        wait_start("tmo_start", 20);
        s = tb_cyc;
        wait_idle("tmo_idle", 60);
        chk("tmo_latency", tb_cyc - s, TMO);
        chk("tmo_flag", {31'b0, o_tx_timeout}, 32'd1);
        chk("tmo_ovf_sticky", {31'b0, o_overflow}, 32'd1);
        e = '{8'h07};
        check_bytes("tmo", e);
        rsp_en = 1'b1;

        // Reset during WAIT_CODE.
        sent.delete();
        pulse(6'b001000, 8'h3C);
        wait_start("rst_start", 20);
        repeat (3) @(negedge clk);
        rsp_en = 1'b0;
        reset_dut();
        n0 = n_starts;
        repeat (25) @(negedge clk);
        chk("rst_no_start", n_starts - n0, 32'd0);
        chk("rst_idle_busy", {31'b0, o_busy}, 32'd0);
        rsp_en = 1'b1;
        sent.delete();
        pulse(6'b100000, 8'h42);
        wait_idle("post_rst_frame", 200);
        e = '{8'h0B, 8'h42};
`ifdef RESPONSE_CHECKSUM_EN
        e.push_back(8'h49);
`endif
        check_bytes("post_rst", e);

        // Randomized traffic with random UART latency and stray done pulses.
        rsp_rand = 1'b1;
        rsp_noise = 1'b1;
        for (int it = 0; it < 250; it++) begin
            logic [5:0] c;
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) c = 6'b0;
            else if (r <= 6) c = 6'(1 << (r - 1));
            else c = 6'($urandom);
            pulse(c, 8'($urandom));
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        rsp_noise = 1'b0;
        wait_idle("drain", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
